// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI responder.
package spi_pkg;

  localparam int                  SPI_WIDTH      = 8;
  localparam logic [SPI_WIDTH-1:0] SPI_TX_DEFAULT = 8'hFF;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one SPI pin with rise/fall detection of the
// synchronized level (last stage vs. one extra registered copy).
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Shift the raw pin through the synchronizer and keep one delayed copy.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = level_o & ~prev_q;
  assign fall_o  = ~level_o & prev_q;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 responder, MSB first, fully oversampled in the clk domain.
// Received words pop out as one-cycle rx_valid pulses; transmit words come
// from a one-entry valid/ready buffer loaded at frame start and after every
// completed word.
module spi_slave
  import spi_pkg::*;
#(
  parameter int               WIDTH       = SPI_WIDTH,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] TX_DEFAULT  = WIDTH'(SPI_TX_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cs_n,
  input  logic             sck,
  input  logic             mosi,
  output logic             miso,
  output logic             miso_oe,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             tx_underrun,
  output logic             frame_abort
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic cs_level, cs_rise, cs_fall;
  logic sck_level, sck_rise, sck_fall;
  logic mosi_level, unused_mosi_rise, unused_mosi_fall, unused_sck_level;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .d_i(cs_n),
    .level_o(cs_level), .rise_o(cs_rise), .fall_o(cs_fall)
  );
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
    .clk(clk), .rst_n(rst_n), .d_i(sck),
    .level_o(sck_level), .rise_o(sck_rise), .fall_o(sck_fall)
  );
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .d_i(mosi),
    .level_o(mosi_level), .rise_o(unused_mosi_rise), .fall_o(unused_mosi_fall)
  );
  assign unused_sck_level = sck_level;

  spi_state_e       state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] rx_shift_q, rx_shift_d, tx_shift_q, tx_shift_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d, tx_buf_q, tx_buf_d;
  logic             rx_valid_q, rx_valid_d, miso_q, miso_d, miso_oe_q, miso_oe_d;
  logic             tx_full_q, tx_full_d, underrun_q, underrun_d, abort_q, abort_d;
  logic [SYNC_STAGES-1:0] settle_q;
  logic             armed_q;
  logic             load, tx_write, consume;
  logic [WIDTH-1:0] load_word;

  // A cs_n fall is only honoured once cs_n has been seen high after reset,
  // so a master still holding cs_n low across reset cannot start a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_q <= '0;
      armed_q  <= 1'b0;
    end else begin
      settle_q <= {settle_q[SYNC_STAGES-2:0], 1'b1};
      armed_q  <= armed_q | (settle_q[SYNC_STAGES-1] & cs_level);
    end
  end

  // State and datapath registers.
  // NOTE: datapath registers are reset as well so every output has a
  // defined value straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      rx_shift_q <= '0;
      tx_shift_q <= '0;
      rx_data_q  <= '0;
      tx_buf_q   <= '0;
      rx_valid_q <= 1'b0;
      miso_q     <= 1'b0;
      miso_oe_q  <= 1'b0;
      tx_full_q  <= 1'b0;
      underrun_q <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_shift_q <= rx_shift_d;
      tx_shift_q <= tx_shift_d;
      rx_data_q  <= rx_data_d;
      tx_buf_q   <= tx_buf_d;
      rx_valid_q <= rx_valid_d;
      miso_q     <= miso_d;
      miso_oe_q  <= miso_oe_d;
      tx_full_q  <= tx_full_d;
      underrun_q <= underrun_d;
      abort_q    <= abort_d;
    end
  end

  assign load_word = tx_full_q ? tx_buf_q : TX_DEFAULT;
  assign tx_write  = tx_valid && !tx_full_q;
  assign consume   = load && tx_full_q;

  // Frame FSM, shift registers and tx buffer next-state.
  // NOTE: every variable gets a default first so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    miso_d     = miso_q;
    miso_oe_d  = miso_oe_q;
    underrun_d = 1'b0;
    abort_d    = 1'b0;
    load       = 1'b0;

    case (state_q)
      IDLE: begin
        miso_oe_d = 1'b0;
        if (cs_fall && armed_q) begin
          load      = 1'b1;
          bit_cnt_d = '0;
          miso_oe_d = 1'b1;
          state_d   = ACTIVE;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          // cs_n wins over any simultaneous sck edge.
          state_d   = IDLE;
          miso_oe_d = 1'b0;
          miso_d    = 1'b0;
          bit_cnt_d = '0;
          abort_d   = (bit_cnt_q != '0);
        end else if (sck_rise) begin
          rx_shift_d = {rx_shift_q[WIDTH-2:0], mosi_level};
          if (bit_cnt_q == LAST_BIT) begin
            rx_data_d  = {rx_shift_q[WIDTH-2:0], mosi_level};
            rx_valid_d = 1'b1;
            bit_cnt_d  = '0;
            load       = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else if (sck_fall && bit_cnt_q != '0) begin
          // Word boundary (bit_cnt 0) holds the freshly loaded MSB.
          tx_shift_d = tx_shift_q << 1;
          miso_d     = tx_shift_q[WIDTH-2];
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      tx_shift_d = load_word;
      miso_d     = load_word[WIDTH-1];
      underrun_d = !tx_full_q;
    end

    tx_full_d = tx_write | (tx_full_q & ~consume);
    tx_buf_d  = tx_write ? tx_data : tx_buf_q;
  end

  assign miso        = miso_q;
  assign miso_oe     = miso_oe_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_ready    = ~tx_full_q;
  assign tx_underrun = underrun_q;
  assign frame_abort = abort_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a mode-0 master model drives the pins
// on clk falling edges (10 MHz clk, 100 kHz SCK) and monitors count pulses.
`timescale 1ns/1ps
module tb_spi_slave;

  localparam int HALF = 50;  // clk cycles per SCK half period
  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       cs_n = 1'b1, sck = 1'b0, mosi = 1'b0;
  logic       miso, miso_oe, rx_valid, tx_ready, tx_underrun, frame_abort;
  logic [7:0] rx_data, tx_data = 8'h00;
  logic       tx_valid = 1'b0;

  int tests_run = 0, tests_failed = 0;
  int rx_cnt = 0, ur_cnt = 0, ab_cnt = 0;
  logic [7:0] rx_log[$];

  spi_slave #(.WIDTH(8), .SYNC_STAGES(SYNC), .TX_DEFAULT(8'hFF)) dut (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .sck(sck), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_underrun(tx_underrun), .frame_abort(frame_abort)
  );

  always #50 clk = ~clk;

  // Pulse monitors: each high sample is one cycle of the pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid === 1'b1) begin rx_cnt++; rx_log.push_back(rx_data); end
      if (tx_underrun === 1'b1) ur_cnt++;
      if (frame_abort === 1'b1) ab_cnt++;
    end
  end

  initial begin
    #20ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_fall();
    @(negedge clk); cs_n = 1'b0; wait_neg(10);
  endtask

  task automatic cs_rise();
    wait_neg(HALF); cs_n = 1'b1; wait_neg(10);
  endtask

  // Master shifts n bits MSB first; samples miso just before each rise.
  // lat = clk falling edges from an sck rise to the first rx_valid seen.
  task automatic master_bits(input logic [7:0] tx, input int n,
                             output logic [7:0] rx, output int lat);
    rx = 8'h00; lat = -1;
    for (int i = 0; i < n; i++) begin
      mosi = tx[7-i];
      wait_neg(HALF);
      rx = {rx[6:0], miso};
      sck = 1'b1;
      for (int k = 1; k <= HALF; k++) begin
        @(negedge clk);
        if (lat < 0 && rx_valid === 1'b1) lat = k;
      end
      sck = 1'b0;
    end
  endtask

  task automatic tx_write(input logic [7:0] d);
    int t = 0;
    @(negedge clk);
    while (tx_ready !== 1'b1 && t < 1000) begin @(negedge clk); t++; end
    if (t >= 1000) begin
      tests_failed++;
      $display("FAIL tx_write_timeout: tx_ready got %b expected 1", tx_ready);
    end
    tests_run++;
    tx_data = d; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; #20; rst_n = 1'b0; #20;
    if (miso !== 1'b0)       begin tests_failed++; $display("FAIL rst_miso: got %b expected 0", miso); end
    if (miso_oe !== 1'b0)    begin tests_failed++; $display("FAIL rst_miso_oe: got %b expected 0", miso_oe); end
    if (rx_data !== 8'h00)   begin tests_failed++; $display("FAIL rst_rx_data: got %h expected 00", rx_data); end
    if (rx_valid !== 1'b0)   begin tests_failed++; $display("FAIL rst_rx_valid: got %b expected 0", rx_valid); end
    if (tx_ready !== 1'b1)   begin tests_failed++; $display("FAIL rst_tx_ready: got %b expected 1", tx_ready); end
    if (tx_underrun !== 1'b0) begin tests_failed++; $display("FAIL rst_underrun: got %b expected 0", tx_underrun); end
    if (frame_abort !== 1'b0) begin tests_failed++; $display("FAIL rst_abort: got %b expected 0", frame_abort); end
    tests_run += 7;
    wait_neg(3); rst_n = 1'b1; wait_neg(10);
  endtask

  task automatic test_basic();
    logic [7:0] got; int lat; int r0, u0;
    r0 = rx_cnt; u0 = ur_cnt;
    tx_write(8'h3C);
    if (tx_ready !== 1'b0) begin tests_failed++; $display("FAIL basic_ready_after_write: got %b expected 0", tx_ready); end
    tests_run++;
    cs_fall();
    if (miso_oe !== 1'b1) begin tests_failed++; $display("FAIL basic_miso_oe: got %b expected 1", miso_oe); end
    if (ur_cnt != u0)     begin tests_failed++; $display("FAIL basic_no_underrun_at_start: got %0d expected %0d", ur_cnt, u0); end
    if (tx_ready !== 1'b1) begin tests_failed++; $display("FAIL basic_ready_after_load: got %b expected 1", tx_ready); end
    tests_run += 3;
    master_bits(8'hAA, 8, got, lat);
    cs_rise();
    if (rx_cnt - r0 != 1)  begin tests_failed++; $display("FAIL basic_rx_pulses: got %0d expected 1", rx_cnt - r0); end
    if (rx_data !== 8'hAA) begin tests_failed++; $display("FAIL basic_rx_data: got %h expected aa", rx_data); end
    if (got !== 8'h3C)     begin tests_failed++; $display("FAIL basic_miso_word: got %h expected 3c", got); end
    if (lat != SYNC + 1)   begin tests_failed++; $display("FAIL basic_latency: got %0d expected %0d", lat, SYNC + 1); end
    if (miso_oe !== 1'b0)  begin tests_failed++; $display("FAIL basic_oe_after_cs: got %b expected 0", miso_oe); end
    tests_run += 5;
  endtask

  task automatic test_underrun();
    logic [7:0] got; int lat; int r0, u0;
    r0 = rx_cnt; u0 = ur_cnt;
    cs_fall();
    if (ur_cnt - u0 != 1) begin tests_failed++; $display("FAIL ur_at_start: got %0d expected 1", ur_cnt - u0); end
    tests_run++;
    master_bits(8'h55, 8, got, lat);
    cs_rise();
    if (got !== 8'hFF)     begin tests_failed++; $display("FAIL ur_miso_word: got %h expected ff", got); end
    if (rx_data !== 8'h55) begin tests_failed++; $display("FAIL ur_rx_data: got %h expected 55", rx_data); end
    if (rx_cnt - r0 != 1)  begin tests_failed++; $display("FAIL ur_rx_pulses: got %0d expected 1", rx_cnt - r0); end
    // The word-end reload also finds the buffer empty.
    if (ur_cnt - u0 != 2)  begin tests_failed++; $display("FAIL ur_total: got %0d expected 2", ur_cnt - u0); end
    tests_run += 4;
  endtask

  task automatic test_back_to_back();
    logic [7:0] g1, g2; int lat; int r0, u0;
    r0 = rx_cnt; u0 = ur_cnt;
    tx_write(8'hC3);
    cs_fall();
    tx_write(8'h5A);
    if (tx_ready !== 1'b0) begin tests_failed++; $display("FAIL b2b_ready: got %b expected 0", tx_ready); end
    tests_run++;
    master_bits(8'h01, 8, g1, lat);
    master_bits(8'h80, 8, g2, lat);
    cs_rise();
    if (rx_cnt - r0 != 2) begin
      tests_failed++; $display("FAIL b2b_rx_pulses: got %0d expected 2", rx_cnt - r0);
    end else begin
      if (rx_log[r0] !== 8'h01)   begin tests_failed++; $display("FAIL b2b_rx0: got %h expected 01", rx_log[r0]); end
      if (rx_log[r0+1] !== 8'h80) begin tests_failed++; $display("FAIL b2b_rx1: got %h expected 80", rx_log[r0+1]); end
      tests_run += 2;
    end
    if (g1 !== 8'hC3)     begin tests_failed++; $display("FAIL b2b_miso0: got %h expected c3", g1); end
    if (g2 !== 8'h5A)     begin tests_failed++; $display("FAIL b2b_miso1: got %h expected 5a", g2); end
    if (ur_cnt - u0 != 1) begin tests_failed++; $display("FAIL b2b_underrun: got %0d expected 1", ur_cnt - u0); end
    tests_run += 4;
  endtask

  task automatic test_abort();
    logic [7:0] got; int lat; int r0, a0;
    r0 = rx_cnt; a0 = ab_cnt;
    cs_fall();
    master_bits(8'hB7, 5, got, lat);
    cs_rise();
    if (ab_cnt - a0 != 1)  begin tests_failed++; $display("FAIL abort_pulse: got %0d expected 1", ab_cnt - a0); end
    if (rx_cnt != r0)      begin tests_failed++; $display("FAIL abort_no_rx: got %0d expected %0d", rx_cnt, r0); end
    if (rx_data !== 8'h80) begin tests_failed++; $display("FAIL abort_rx_kept: got %h expected 80", rx_data); end
    tests_run += 3;
    cs_fall();
    master_bits(8'hF0, 8, got, lat);
    cs_rise();
    if (rx_data !== 8'hF0) begin tests_failed++; $display("FAIL abort_next_rx: got %h expected f0", rx_data); end
    if (ab_cnt - a0 != 1)  begin tests_failed++; $display("FAIL abort_next_clean: got %0d expected 1", ab_cnt - a0); end
    tests_run += 2;
  endtask

  task automatic test_reset_midframe();
    logic [7:0] got; int lat; int r0;
    cs_fall();
    master_bits(8'hA5, 3, got, lat);
    rst_n = 1'b0; #1;
    if (miso_oe !== 1'b0)  begin tests_failed++; $display("FAIL mrst_miso_oe: got %b expected 0", miso_oe); end
    if (miso !== 1'b0)     begin tests_failed++; $display("FAIL mrst_miso: got %b expected 0", miso); end
    if (rx_data !== 8'h00) begin tests_failed++; $display("FAIL mrst_rx_data: got %h expected 00", rx_data); end
    if (tx_ready !== 1'b1) begin tests_failed++; $display("FAIL mrst_tx_ready: got %b expected 1", tx_ready); end
    tests_run += 4;
    wait_neg(3); rst_n = 1'b1;
    r0 = rx_cnt;
    master_bits(8'h3C, 8, got, lat);
    wait_neg(HALF);
    if (rx_cnt != r0)     begin tests_failed++; $display("FAIL mrst_no_rx: got %0d expected %0d", rx_cnt, r0); end
    if (miso_oe !== 1'b0) begin tests_failed++; $display("FAIL mrst_stay_idle: got %b expected 0", miso_oe); end
    tests_run += 2;
    cs_rise();
    cs_fall();
    master_bits(8'h96, 8, got, lat);
    cs_rise();
    if (rx_cnt - r0 != 1)  begin tests_failed++; $display("FAIL mrst_fresh_pulses: got %0d expected 1", rx_cnt - r0); end
    if (rx_data !== 8'h96) begin tests_failed++; $display("FAIL mrst_fresh_rx: got %h expected 96", rx_data); end
    tests_run += 2;
  endtask

  task automatic test_handshake();
    logic [7:0] w[4];
    logic [7:0] g0, g1, g2;
    int lat, idx, highs, run, maxrun, t;
    bit started, xfer;
    w[0] = 8'h11; w[1] = 8'h22; w[2] = 8'h33; w[3] = 8'h44;
    idx = 0; highs = 0; run = 0; maxrun = 0; t = 0; started = 0;
    fork
      begin
        @(negedge clk);
        tx_data = w[0]; tx_valid = 1'b1;
        while (idx < 4 && t < 4000) begin
          xfer = (tx_ready === 1'b1);
          if (started) begin
            if (tx_ready === 1'b1) begin highs++; run++; end else run = 0;
            if (run > maxrun) maxrun = run;
          end
          @(negedge clk); t++;
          if (xfer) begin
            started = 1;
            idx++;
            if (idx < 4) tx_data = w[idx]; else tx_valid = 1'b0;
          end
        end
        tx_valid = 1'b0;
      end
      begin
        cs_fall();
        master_bits(8'h00, 8, g0, lat);
        master_bits(8'h00, 8, g1, lat);
        master_bits(8'h00, 8, g2, lat);
        cs_rise();
      end
    join
    if (g0 !== 8'h11)  begin tests_failed++; $display("FAIL hs_word0: got %h expected 11", g0); end
    if (g1 !== 8'h22)  begin tests_failed++; $display("FAIL hs_word1: got %h expected 22", g1); end
    if (g2 !== 8'h33)  begin tests_failed++; $display("FAIL hs_word2: got %h expected 33", g2); end
    if (idx != 4)      begin tests_failed++; $display("FAIL hs_words_taken: got %0d expected 4", idx); end
    if (highs != 3)    begin tests_failed++; $display("FAIL hs_ready_cycles: got %0d expected 3", highs); end
    if (maxrun != 1)   begin tests_failed++; $display("FAIL hs_ready_pulse_width: got %0d expected 1", maxrun); end
    tests_run += 6;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_underrun();
    test_back_to_back();
    test_abort();
    test_reset_midframe();
    test_handshake();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI responder (mode 0, CPOL=0, CPHA=0, MSB first) for the far end of the team's SPI master link (CS, clkSeq, MOSI, MISO).
- Oversamples all SPI pins in the local `clk` domain; no logic is clocked by SCK.
- Delivers each received byte as a one-cycle `rx_valid` pulse.
- Shifts out a byte supplied through a valid/ready buffer; the byte is loaded at frame start and after every completed byte.

Parameters:
- WIDTH, 8, bits per SPI word; also the width of rx_data and tx_data.
- SYNC_STAGES, 2, flip-flop synchronizer depth on cs_n, sck and mosi; legal range 2..3.
- TX_DEFAULT, 8'hFF, word shifted out when the tx buffer is empty at load time.

Ports:
- clk  in  1  system clock; must be at least 8x the SCK frequency.
- rst_n  in  1  asynchronous, active-low reset.
- cs_n  in  1  chip select from the master (the master's CS), active low.
- sck  in  1  serial clock from the master (the master's clkSeq).
- mosi  in  1  serial data from the master.
- miso  out  1  serial data to the master.
- miso_oe  out  1  high while selected; the pad tri-states miso when low.
- rx_data  out  WIDTH  last complete received word.
- rx_valid  out  1  one-cycle pulse; rx_data is new.
- tx_data  in  WIDTH  next word to transmit.
- tx_valid  in  1  tx_data is offered.
- tx_ready  out  1  tx buffer empty; transfer occurs when tx_valid && tx_ready.
- tx_underrun  out  1  one-cycle pulse; TX_DEFAULT was loaded instead of user data.
- frame_abort  out  1  one-cycle pulse; cs_n rose with a partial word in progress.

Behaviour:
- Reset values (async on rst_n low): miso=0, miso_oe=0, rx_data=0, rx_valid=0, tx_ready=1, tx_underrun=0, frame_abort=0, bit_cnt=0, state=IDLE, synchronizer flops=1 for cs_n and 0 for sck/mosi.
- Synchronization: cs_n, sck and mosi each pass through SYNC_STAGES flops. Edge detect compares the last stage with one more registered copy. Every "edge" below means an edge of the synchronized signal.
- IDLE: miso_oe=0.
  - On a cs_n falling edge: load tx_shift from the tx buffer, or TX_DEFAULT with a tx_underrun pulse if the buffer is empty.
  - In the same cycle: bit_cnt=0, miso=tx_shift MSB, miso_oe=1, go to ACTIVE.
- ACTIVE, sck rising edge:
  - rx_shift = {rx_shift[WIDTH-2:0], mosi_sync}; bit_cnt+1.
  - When bit_cnt reaches WIDTH:
    - rx_data <= assembled word; rx_valid=1 for exactly one clk cycle.
    - bit_cnt=0.
    - Reload tx_shift using the same buffer/default/underrun rule as frame start.
    - miso updates to the new MSB on the next cycle.
- ACTIVE, sck falling edge: if bit_cnt != 0, shift tx_shift left and update miso to the new MSB. If bit_cnt == 0, no shift, so the reloaded MSB stays stable for the next rising edge.
- ACTIVE, cs_n rising edge: go to IDLE, miso_oe=0.
  - If bit_cnt != 0: pulse frame_abort and discard the partial word; rx_data and rx_valid are unaffected.
  - bit_cnt=0.
- cs_n rise and sck edge in the same cycle: cs_n wins; the sck edge is ignored.
- sck edges seen in IDLE are ignored.
- tx buffer: one entry.
  - Written when tx_valid && tx_ready; tx_ready then falls on the next cycle.
  - A load that consumes the entry raises tx_ready on the next cycle.
  - Write and consume in the same cycle: the consume takes the old content and the new write fills the buffer, so tx_ready stays 0.
- Latency: rx_valid asserts SYNC_STAGES+1 clk cycles after the 8th SCK rising edge at the pin.
- Reset mid-frame: everything returns to reset values. After rst_n rises, a new frame starts only on a subsequent cs_n falling edge; if cs_n is already low, nothing happens until it rises and falls again.

Decomposition:
- Shared package spi_pkg:
  - SPI_WIDTH=8.
  - SPI_TX_DEFAULT=8'hFF.
  - State encoding localparams: IDLE=1'b0, ACTIVE=1'b1.
- One sub-module: spi_sync_edge, a per-pin SYNC_STAGES synchronizer plus rise/fall detect. Instantiated three times: cs_n, sck, mosi (mosi uses level only).

Test Plan:
- Basic receive: preload tx 8'h3C; master sends 8'hAA with clk=10 MHz, SCK=100 kHz -> one rx_valid pulse, rx_data=8'hAA; master samples 8'h3C on MISO; tx_underrun never pulses.
- Underrun: no tx write; frame of 8'h55 -> tx_underrun pulses at the cs_n fall; master receives 8'hFF; rx_data=8'h55.
- Back-to-back: two-word frame 8'h01, 8'h80 under one CS; tx preloaded 8'hC3, second word written after the first load -> rx_valid pulses twice (8'h01, then 8'h80); master receives 8'hC3 then the second word; no shift glitch at the word boundary.
- Abort: cs_n rises after 5 SCK rising edges -> frame_abort pulse; rx_valid stays 0; next full frame of 8'hF0 gives rx_data=8'hF0.
- Reset mid-frame: rst_n low after 3 bits -> all outputs at reset values within the same cycle; miso_oe=0; with cs_n still low after release, no rx_valid until a fresh cs_n fall.
- Handshake: tx_valid held high continuously -> tx_ready is 0 after the first write and pulses 1 for exactly one cycle per load; each offered word is transmitted exactly once, in order.
